fir_mac_arbiter: RTL and testbench

//   Shares one multiply-accumulate engine among NUM_REQ FIR channels (I/Q channel filters, L+R/L-R audio).

---
 rtl/fir_mac_arbiter_pkg.sv | 20 ++
 rtl/fir_mac_unit.sv | 36 +++
 rtl/fir_mac_arbiter.sv | 135 +++++++++++++
 tb/tb_fir_mac_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_mac_arbiter_pkg.sv
// Shared definitions for the FIR MAC arbiter: quantization, FSM states and
// the dequantize helper used by the MAC datapath.
package fir_mac_arbiter_pkg;

  // Fractional bits of the product that are dropped when returning to sample scale
  localparam int QUANT_BITS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

  // Arithmetic shift back to sample scale; callers sign-extend into and
  // truncate out of this wide container (products up to 128 bits).
  function automatic logic signed [127:0] dequantize(input logic signed [127:0] p);
    return p >>> QUANT_BITS;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Multiply, dequantize and accumulate one tap per enabled cycle.
// acc_next is the value the accumulator takes on this edge, so the owner of
// the unit can capture a finished sum in the same cycle as the last tap.
module fir_mac_unit
  import fir_mac_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MULT_WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] acc_next
);

  logic signed [MULT_WIDTH-1:0] prod;
  logic signed [DATA_WIDTH-1:0] d;
  logic signed [DATA_WIDTH-1:0] acc;

  // Full-precision signed product, scaled down, wrapped into DATA_WIDTH
  always_comb begin
    prod     = MULT_WIDTH'(a) * MULT_WIDTH'(b);
    d        = DATA_WIDTH'(dequantize(128'(prod)));
    acc_next = clear ? d : acc + d;
  end

  // Accumulator: clear loads the first tap, otherwise wrap-around add
  always_ff @(posedge clk) begin
    if (rst)     acc <= '0;
    else if (en) acc <= acc_next;
  end

endmodule

// File: rtl/fir_mac_arbiter.sv
// Round-robin owner of a single MAC engine. Each grant is a whole burst of
// TAPS products; the owner feeds sample/coeff for tap_idx, and gets the
// dequantized dot product back with a one-cycle done pulse.
module fir_mac_arbiter
  import fir_mac_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int TAPS       = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MULT_WIDTH = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_sample,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_coeff,
  output logic [NUM_REQ-1:0]                  grant,
  output logic [$clog2(TAPS)-1:0]             tap_idx,
  output logic [NUM_REQ-1:0]                  done,
  output logic [DATA_WIDTH-1:0]               result,
  output logic                                busy
);

  localparam int RW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TAPS);
  localparam logic [TW-1:0] LAST_TAP  = TW'(TAPS - 1);
  localparam logic [RW-1:0] LAST_INIT = RW'(NUM_REQ - 1);

  arb_state_t state, state_n;
  logic [RW-1:0]         owner, owner_n, last, last_n, sel;
  logic [NUM_REQ-1:0]    grant_n, done_n;
  logic [TW-1:0]         tap_n;
  logic [DATA_WIDTH-1:0] result_n;
  logic                  busy_n;
  logic                  mac_en, mac_clear;
  logic signed [DATA_WIDTH-1:0] mac_a, mac_b, mac_sum;

  // Operand mux: the owner presents data for the current tap combinationally
  assign mac_a = req_sample[owner];
  assign mac_b = req_coeff[owner];

  fir_mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .MULT_WIDTH (MULT_WIDTH)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clear    (mac_clear),
    .en       (mac_en),
    .a        (mac_a),
    .b        (mac_b),
    .acc_next (mac_sum)
  );

  // Round-robin pick: nearest requester after last wins; last itself is
  // checked first here so that every closer candidate overrides it
  always_comb begin
    sel = last;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[(int'(last) + i) % NUM_REQ]) sel = RW'((int'(last) + i) % NUM_REQ);
    end
  end

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_n   = state;
    owner_n   = owner;
    last_n    = last;
    grant_n   = '0;
    done_n    = '0;
    tap_n     = tap_idx;
    result_n  = result;
    busy_n    = busy;
    mac_en    = 1'b0;
    mac_clear = 1'b0;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        tap_n  = '0;
        if (|req) begin
          state_n      = BURST;
          owner_n      = sel;
          grant_n[sel] = 1'b1;
          busy_n       = 1'b1;
        end
      end
      BURST: begin
        mac_en    = 1'b1;
        mac_clear = (tap_idx == '0);
        if (tap_idx == LAST_TAP) begin
          state_n        = DONE;
          tap_n          = '0;
          done_n[owner]  = 1'b1;
          result_n       = mac_sum;
        end else begin
          grant_n = grant;
          tap_n   = tap_idx + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        last_n  = owner;
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any burst with no done
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= '0;
      last    <= LAST_INIT;
      grant   <= '0;
      done    <= '0;
      tap_idx <= '0;
      result  <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      owner   <= owner_n;
      last    <= last_n;
      grant   <= grant_n;
      done    <= done_n;
      tap_idx <= tap_n;
      result  <= result_n;
      busy    <= busy_n;
    end
  end

endmodule

// File: tb/tb_fir_mac_arbiter.sv
// Bench for fir_mac_arbiter: directed scenarios with literal results plus a
// randomized phase, all checked each cycle against a burst-level model.
module tb_fir_mac_arbiter;

  localparam int NR   = 4;
  localparam int TAPS = 4;
  localparam int DW   = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NR-1:0]          req;
  logic [NR-1:0][DW-1:0]  req_sample, req_coeff;
  logic [NR-1:0]          grant, done;
  logic [1:0]             tap_idx;
  logic [DW-1:0]          result;
  logic                   busy;

  int samp [NR][TAPS];
  int coef [NR][TAPS];

  int n_checks = 0;
  int n_errors = 0;

  fir_mac_arbiter #(.NUM_REQ(NR), .TAPS(TAPS), .DATA_WIDTH(DW), .MULT_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .req(req), .req_sample(req_sample), .req_coeff(req_coeff),
    .grant(grant), .tap_idx(tap_idx), .done(done), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Channels answer the tap index the arbiter is asking for
  always_comb begin
    for (int c = 0; c < NR; c++) begin
      req_sample[c] = samp[c][tap_idx];
      req_coeff[c]  = coef[c][tap_idx];
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // ---------------- burst-level reference model ----------------
  int          m_owner, m_t, m_last, m_exp;
  logic [31:0] m_result;
  bit          started = 0;

  function automatic int exp_sum(input int c);
    int acc = 0;
    for (int t = 0; t < TAPS; t++) begin
      longint p = longint'(samp[c][t]) * longint'(coef[c][t]);
      acc += int'(p >>> 10);
    end
    return acc;
  endfunction

  function automatic int pick();
    for (int k = 1; k <= NR; k++)
      if (req[(m_last + k) % NR]) return (m_last + k) % NR;
    return -1;
  endfunction

  // One arbitration cycle, TAPS granted cycles, one done cycle, then idle
  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      m_owner <= -1; m_t <= 0; m_last <= NR - 1; m_result <= '0;
    end else if (m_owner < 0) begin
      if (|req) begin
        m_owner <= pick(); m_t <= 0; m_exp <= exp_sum(pick());
      end
    end else if (m_t < TAPS) begin
      m_t <= m_t + 1;
      if (m_t == TAPS - 1) m_result <= m_exp;
    end else begin
      m_last <= m_owner; m_owner <= -1; m_t <= 0;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (started) begin
      chk("grant", 32'(grant),
          (m_owner >= 0 && m_t < TAPS) ? (32'd1 << m_owner) : 32'd0);
      chk("tap_idx", 32'(tap_idx), (m_owner >= 0 && m_t < TAPS) ? 32'(m_t) : 32'd0);
      chk("done", 32'(done),
          (m_owner >= 0 && m_t == TAPS) ? (32'd1 << m_owner) : 32'd0);
      chk("busy", 32'(busy), 32'(m_owner >= 0));
      chk("result", result, m_result);
    end
  end

  int done_q [$];
  always @(negedge clk)
    for (int c = 0; c < NR; c++) if (done[c]) done_q.push_back(c);

  // ---------------- stimulus helpers ----------------
  task automatic wait_done(input int c, output logic [31:0] res);
    res = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done[c]) begin res = result; return; end
    end
    chk("timeout_done", 32'd0, 32'd1);
  endtask

  task automatic wait_tap(input int c, input int t);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (grant[c] && int'(tap_idx) == t) return;
    end
    chk("timeout_tap", 32'd0, 32'd1);
  endtask

  task automatic rand_data(input int c);
    for (int t = 0; t < TAPS; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        samp[c][t] = int'($urandom_range(0, 4095)) - 2048;
        coef[c][t] = int'($urandom_range(0, 4095)) - 2048;
      end else begin
        samp[c][t] = int'($urandom);
        coef[c][t] = int'($urandom);
      end
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] r;

  initial begin
    rst = 1'b1;
    req = '0;
    for (int c = 0; c < NR; c++)
      for (int t = 0; t < TAPS; t++) begin samp[c][t] = 0; coef[c][t] = 0; end
    repeat (3) @(negedge clk);
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_result", result, 32'd0);
    rst = 1'b0;

    // Single requester, unity coefficient: result is the plain sample sum
    for (int t = 0; t < TAPS; t++) begin samp[2][t] = t + 1; coef[2][t] = 1024; end
    req[2] = 1'b1;
    wait_done(2, r);
    req[2] = 1'b0;
    chk("single_result", r, 32'd10);
    repeat (2) @(negedge clk);

    // Simultaneous req0/req1 after reset: req0 first, then req1
    pulse_rst();
    rand_data(0); rand_data(1);
    done_q.delete();
    req[0] = 1'b1; req[1] = 1'b1;
    wait_done(0, r); req[0] = 1'b0;
    wait_done(1, r); req[1] = 1'b0;
    @(negedge clk);
    chk("pair_count", 32'(done_q.size()), 32'd2);
    if (done_q.size() == 2) begin
      chk("pair_first", 32'(done_q[0]), 32'd0);
      chk("pair_second", 32'(done_q[1]), 32'd1);
    end
    repeat (2) @(negedge clk);

    // All four held: order 0,1,2,3,0
    pulse_rst();
    for (int c = 0; c < NR; c++) rand_data(c);
    done_q.delete();
    req = '1;
    wait_done(0, r); wait_done(1, r); wait_done(2, r); wait_done(3, r); wait_done(0, r);
    req = '0;
    @(negedge clk);
    chk("rr_count", 32'(done_q.size()), 32'd5);
    if (done_q.size() == 5)
      for (int i = 0; i < 5; i++) chk("rr_order", 32'(done_q[i]), 32'(i % NR));
    repeat (3) @(negedge clk);

    // Negative products
    for (int t = 0; t < TAPS; t++) begin samp[1][t] = -3; coef[1][t] = 2048; end
    req[1] = 1'b1;
    wait_done(1, r); req[1] = 1'b0;
    chk("neg_result", r, 32'hFFFF_FFE8);
    repeat (2) @(negedge clk);

    // Large operands wrap instead of saturating
    for (int t = 0; t < TAPS; t++) begin samp[3][t] = 32'h7FFF_FFFF; coef[3][t] = 32'h7FFF_FFFF; end
    req[3] = 1'b1;
    wait_done(3, r); req[3] = 1'b0;
    chk("wrap_result", r, 32'hFF00_0000);
    repeat (2) @(negedge clk);

    // Reset at tap 2 aborts; the held request then gets a fresh burst
    for (int t = 0; t < TAPS; t++) begin samp[0][t] = t + 1; coef[0][t] = 1024; end
    req[0] = 1'b1;
    wait_tap(0, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_grant", 32'(grant), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    wait_done(0, r); req[0] = 1'b0;
    chk("post_abort_result", r, 32'd10);
    repeat (2) @(negedge clk);

    // Request dropped mid-burst still completes; result then holds
    for (int t = 0; t < TAPS; t++) begin samp[1][t] = t + 5; coef[1][t] = 1024; end
    req[1] = 1'b1;
    wait_tap(1, 1);
    req[1] = 1'b0;
    wait_done(1, r);
    chk("drop_result", r, 32'd26);
    repeat (3) @(negedge clk);
    chk("drop_hold", result, 32'd26);

    // Randomized traffic
    repeat (600) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      for (int c = 0; c < NR; c++) begin
        if (req[c]) begin
          if (done[c] && $urandom_range(0, 1) == 1) req[c] = 1'b0;
          else if (m_owner == c && grant[c] && $urandom_range(0, 19) == 0) req[c] = 1'b0;
        end else if (m_owner != c && $urandom_range(0, 3) == 0) begin
          rand_data(c);
          req[c] = 1'b1;
        end
      end
    end
    req = '0;
    rst = 1'b0;
    repeat (TAPS + 4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
